// File: rtl/multiplier.sv
// Sequential IEEE-754 single-precision multiplier driven by an exec/done
// strobe handshake shared with the divider, so one sequencer can drive both.
//
// state          | meaning
// ---------------|----------------------------------------------------------
// IDLE           | wait for exec strobe, capture operands
// UNPACK         | split operands into sign / mantissa / unbiased exponent
// SPECIAL_CASES  | NaN / inf / zero short-cut, else restore hidden bit
// NORMALIZE_A    | left-shift A mantissa until bit 23 is set
// NORMALIZE_B    | left-shift B mantissa until bit 23 is set
// MULTIPLY_0     | sign, exponent sum, 48-bit mantissa product
// MULTIPLY_1     | extract mantissa plus guard / round / sticky
// NORMALIZE_0    | left-shift result while unnormalized and above min exp
// NORMALIZE_1    | right-shift result while below min exp (denormal)
// ROUND          | round to nearest, ties to even
// PACK           | assemble result word, saturate to inf on overflow
// DONE           | one-cycle completion pulse
module multiplier (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] a_value_i,
  input  logic [31:0] b_value_i,
  input  logic        exec_strobe_i,
  output logic [31:0] z_value_o,
  output logic        done_strobe_o
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL_CASES, NORMALIZE_A, NORMALIZE_B, MULTIPLY_0,
    MULTIPLY_1, NORMALIZE_0, NORMALIZE_1, ROUND, PACK, DONE
  } state_t;

  localparam logic signed [9:0] E_MIN      = -10'sd126;
  localparam logic signed [9:0] E_MAX      = 10'sd127;
  localparam logic signed [9:0] E_ALL_ONES = 10'sd128;
  localparam logic signed [9:0] E_ZERO_FLD = -10'sd127;

  state_t state, next_state;

  logic [31:0]       a_reg, b_reg;
  logic [23:0]       a_m, b_m, z_m;
  logic signed [9:0] a_e, b_e, z_e;
  logic              a_s, b_s, z_s;
  logic [47:0]       product;
  logic              guard, round_bit, sticky;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special_hit;
  logic [7:0] exp_field;

  assign a_nan  = (a_e == E_ALL_ONES) && (a_m != 24'd0);
  assign b_nan  = (b_e == E_ALL_ONES) && (b_m != 24'd0);
  assign a_inf  = (a_e == E_ALL_ONES) && (a_m == 24'd0);
  assign b_inf  = (b_e == E_ALL_ONES) && (b_m == 24'd0);
  assign a_zero = (a_e == E_ZERO_FLD) && (a_m == 24'd0);
  assign b_zero = (b_e == E_ZERO_FLD) && (b_m == 24'd0);
  assign special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Biased exponent; a result left at the minimum exponent without its
  // hidden bit is a denormal and packs with a zero exponent field.
  assign exp_field = (z_e == E_MIN && !z_m[23]) ? 8'd0 : 8'(z_e + 10'sd127);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset_i) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic. Shift states look one step ahead so the cycle that
  // performs the final shift also leaves the state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:          if (exec_strobe_i) next_state = UNPACK;
      UNPACK:        next_state = SPECIAL_CASES;
      SPECIAL_CASES: next_state = special_hit ? DONE : NORMALIZE_A;
      NORMALIZE_A:   if (a_m[23] || a_m[22]) next_state = NORMALIZE_B;
      NORMALIZE_B:   if (b_m[23] || b_m[22]) next_state = MULTIPLY_0;
      MULTIPLY_0:    next_state = MULTIPLY_1;
      MULTIPLY_1:    next_state = NORMALIZE_0;
      NORMALIZE_0:
        if (!(!z_m[23] && z_e > E_MIN && !z_m[22] && z_e > -10'sd125))
          next_state = NORMALIZE_1;
      NORMALIZE_1:   if (!(z_e < -10'sd127)) next_state = ROUND;
      ROUND:         next_state = PACK;
      PACK:          next_state = DONE;
      DONE:          next_state = IDLE;
      default:       next_state = IDLE;
    endcase
  end

  // Output logic: done is high exactly while the FSM sits in DONE.
  always_comb begin
    done_strobe_o = (state == DONE);
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      z_value_o <= 32'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      a_m       <= 24'd0;
      b_m       <= 24'd0;
      z_m       <= 24'd0;
      a_e       <= 10'sd0;
      b_e       <= 10'sd0;
      z_e       <= 10'sd0;
      a_s       <= 1'b0;
      b_s       <= 1'b0;
      z_s       <= 1'b0;
      product   <= 48'd0;
      guard     <= 1'b0;
      round_bit <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exec_strobe_i) begin
            a_reg <= a_value_i;
            b_reg <= b_value_i;
          end
        end
        UNPACK: begin
          a_m <= {1'b0, a_reg[22:0]};
          b_m <= {1'b0, b_reg[22:0]};
          a_e <= $signed({2'b00, a_reg[30:23]}) - 10'sd127;
          b_e <= $signed({2'b00, b_reg[30:23]}) - 10'sd127;
          a_s <= a_reg[31];
          b_s <= b_reg[31];
        end
        SPECIAL_CASES: begin
          if (a_nan || b_nan)
            z_value_o <= 32'hFFC0_0000;
          else if ((a_inf && b_zero) || (b_inf && a_zero))
            z_value_o <= 32'hFFC0_0000;
          else if (a_inf || b_inf)
            z_value_o <= {a_s ^ b_s, 8'hFF, 23'd0};
          else if (a_zero || b_zero)
            z_value_o <= {a_s ^ b_s, 31'd0};
          else begin
            if (a_e == E_ZERO_FLD) a_e <= E_MIN;
            else                   a_m[23] <= 1'b1;
            if (b_e == E_ZERO_FLD) b_e <= E_MIN;
            else                   b_m[23] <= 1'b1;
          end
        end
        NORMALIZE_A: begin
          if (!a_m[23]) begin
            a_m <= {a_m[22:0], 1'b0};
            a_e <= a_e - 10'sd1;
          end
        end
        NORMALIZE_B: begin
          if (!b_m[23]) begin
            b_m <= {b_m[22:0], 1'b0};
            b_e <= b_e - 10'sd1;
          end
        end
        MULTIPLY_0: begin
          z_s     <= a_s ^ b_s;
          z_e     <= a_e + b_e + 10'sd1;
          product <= {24'd0, a_m} * {24'd0, b_m};
        end
        MULTIPLY_1: begin
          z_m       <= product[47:24];
          guard     <= product[23];
          round_bit <= product[22];
          sticky    <= |product[21:0];
        end
        NORMALIZE_0: begin
          if (!z_m[23] && z_e > E_MIN) begin
            z_e       <= z_e - 10'sd1;
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
          end
        end
        NORMALIZE_1: begin
          if (z_e < E_MIN) begin
            z_e       <= z_e + 10'sd1;
            z_m       <= {1'b0, z_m[23:1]};
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end
        end
        ROUND: begin
          if (guard && (round_bit || sticky || z_m[0])) begin
            z_m <= z_m + 24'd1;
            if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
          end
        end
        PACK: begin
          if (z_e > E_MAX) z_value_o <= {z_s, 8'hFF, 23'd0};
          else             z_value_o <= {z_s, exp_field, z_m[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The module SHALL have these ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 The module SHALL have these ports: reset_i  input  1  synchronous, active-low reset.
REQ-003 The module SHALL have these ports: a_value_i  input  32  IEEE-754 single operand A.
REQ-004 The module SHALL have these ports: b_value_i  input  32  IEEE-754 single operand B.
REQ-005 The module SHALL have these ports: exec_strobe_i  input  1  start request, one-cycle pulse.
REQ-006 The module SHALL have these ports: z_value_o  output  32  product A*B, registered.
REQ-007 The module SHALL have these ports: done_strobe_o  output  1  one-cycle completion pulse.
REQ-008 The module SHALL have no parameters.

Function
REQ-009 The module SHALL implement the same exec/done strobe protocol as the FPU divider, so one sequencer drives both units.
REQ-010 The FSM SHALL have these states: IDLE, UNPACK, SPECIAL_CASES, NORMALIZE_A, NORMALIZE_B, MULTIPLY_0, MULTIPLY_1, NORMALIZE_0, NORMALIZE_1, ROUND, PACK, DONE.
REQ-011 In IDLE, when exec_strobe_i=1, the module SHALL capture a_value_i and b_value_i into internal registers and go to UNPACK; operand inputs are don't-care afterwards.
REQ-012 exec_strobe_i SHALL be ignored in every state other than IDLE.
REQ-013 UNPACK SHALL split each operand into sign, 24-bit mantissa (hidden bit 0), and 10-bit signed exponent (field - 127); go to SPECIAL_CASES.
REQ-014 SPECIAL_CASES SHALL apply this priority and go directly to DONE on any hit:
- any NaN input -> 0xFFC00000;
- inf times zero -> 0xFFC00000;
- any inf -> sign a_s^b_s, exp 255, mantissa 0;
- any zero -> sign a_s^b_s, all other bits 0.
REQ-015 Otherwise, SPECIAL_CASES SHALL set hidden bit 1 for normal operands, set exponent to -126 for denormal operands, and go to NORMALIZE_A.
REQ-016 NORMALIZE_A and NORMALIZE_B SHALL each shift the mantissa left by 1 and decrement the exponent per cycle until bit 23 is set, with one cycle minimum in each state.
REQ-017 MULTIPLY_0 SHALL compute:
- z_s = a_s^b_s;
- z_e = a_e + b_e + 1;
- 48-bit product = a_m*b_m.
REQ-018 MULTIPLY_1 SHALL set z_m = product[47:24], guard = [23], round = [22], sticky = OR of [21:0].
REQ-019 NORMALIZE_0 SHALL run one left shift per cycle while z_m[23]=0 and z_e > -126: z_e-1, z_m shifted in from guard, guard<=round, round<=0.
REQ-020 NORMALIZE_1 SHALL run one right shift per cycle while z_e < -126: z_e+1, guard<=z_m[0], round<=guard, sticky|=round.
REQ-021 ROUND SHALL use round-to-nearest-even: increment z_m when guard & (round|sticky|z_m[0]), and increment z_e if z_m was 0xFFFFFF.
REQ-022 PACK SHALL produce the result as follows:
- {z_s, z_e+127, z_m[22:0]};
- exponent field 0 when z_e=-126 and z_m[23]=0 (denormal);
- z_e > 127 -> signed inf.
REQ-023 done_strobe_o SHALL be 1 for exactly the single cycle the FSM is in DONE; DONE SHALL go to IDLE unconditionally.
REQ-024 z_value_o SHALL be updated no later than the DONE cycle and SHALL be held until the next result.
REQ-025 Latency SHALL be measured from the strobe cycle (cycle 0) to the done cycle:
- special case: done in cycle 3;
- normal operands with no normalization or denormal shifts: done in cycle 11;
- each extra shift cycle adds 1.
REQ-026 The earliest next accepted strobe SHALL be the cycle after DONE.
REQ-027 Internal exponent arithmetic SHALL be 10-bit signed; intermediate range -300..+256 SHALL NOT wrap.

Reset
REQ-028 While reset_i=0 at a rising edge, the module SHALL set state to IDLE, done_strobe_o to 0, and z_value_o to 0x00000000.
REQ-029 Reset SHALL take priority over all FSM activity, including mid-operation: the operation SHALL be aborted and no done pulse SHALL follow.
REQ-030 A strobe coincident with reset SHALL be ignored.

Verification
REQ-031 The bench SHALL cover the basic multiply: 0x40000000*0x40400000 (2*3) -> 0x40C00000, done in cycle 11, pulse one cycle wide.
REQ-032 The bench SHALL cover the special cases:
- 0x7FC00000*0x3F800000 -> 0xFFC00000;
- 0x7F800000*0x00000000 -> 0xFFC00000;
- 0xFF800000*0x40000000 -> 0x7F800000 negated, i.e. 0xFF800000.
- All three SHALL complete with done in cycle 3.
REQ-033 The bench SHALL cover rounding and sign:
- 0x3F800001*0x3F800001 -> 0x3F800002;
- 0xBFC00000*0x40000000 -> 0xC0400000.
REQ-034 The bench SHALL cover overflow and underflow:
- 0x7F000000*0x7F000000 -> 0x7F800000;
- 0x00800000*0x3F000000 -> 0x00400000 (denormal result);
- 0x00000001*0x00000001 -> 0x00000000.
REQ-035 The bench SHALL cover back-to-back operation and strobe blocking: a strobe in the cycle after DONE is accepted; a strobe during MULTIPLY_0 is ignored, the result is unchanged, and exactly one done pulse occurs.
REQ-036 The bench SHALL cover reset mid-operation: reset_i=0 during NORMALIZE_0 -> IDLE, done_strobe_o=0, z_value_o=0, and no done pulse afterwards until a new strobe.
